// File: rtl/valu_issue_sequencer_if.sv
// Instruction handshake plus RF-read / VALU-issue / writeback control bundle
// for the vector ALU issue sequencer.
interface valu_issue_sequencer_if #(
  parameter int VIDX_W = 8,
  parameter int BW     = 3
);
  logic              instr_valid;
  logic              instr_ready;
  logic [5:0]        instr_op;
  logic [VIDX_W-1:0] instr_vd;
  logic [VIDX_W-1:0] instr_vs1;
  logic [VIDX_W-1:0] instr_vs2;
  logic              instr_mask;
  logic              rf_rd_en;
  logic [VIDX_W-1:0] rf_rd_vs1;
  logic [VIDX_W-1:0] rf_rd_vs2;
  logic [BW-1:0]     rf_rd_beat;
  logic              valu_valid;
  logic [5:0]        valu_op;
  logic              wb_en;
  logic [VIDX_W-1:0] wb_vd;
  logic [BW-1:0]     wb_beat;
  logic              wb_mask_en;
  logic              instr_done;
  logic              illegal_op;
  logic              busy;

  modport slave (
    input  instr_valid, instr_op, instr_vd, instr_vs1, instr_vs2, instr_mask,
    output instr_ready, rf_rd_en, rf_rd_vs1, rf_rd_vs2, rf_rd_beat,
           valu_valid, valu_op, wb_en, wb_vd, wb_beat, wb_mask_en,
           instr_done, illegal_op, busy
  );

  modport master (
    output instr_valid, instr_op, instr_vd, instr_vs1, instr_vs2, instr_mask,
    input  instr_ready, rf_rd_en, rf_rd_vs1, rf_rd_vs2, rf_rd_beat,
           valu_valid, valu_op, wb_en, wb_vd, wb_beat, wb_mask_en,
           instr_done, illegal_op, busy
  );
endinterface

// File: rtl/valu_issue_sequencer.sv
// Walks one vector ALU instruction at a time through the VALU in beats,
// tracking each beat's writeback tag in a fixed-latency shift pipe.
module valu_issue_sequencer #(
  parameter int VLEN     = 32,
  parameter int LANES    = 4,
  parameter int VALU_LAT = 3,
  parameter int VIDX_W   = 8
) (
  input logic                CLK,
  input logic                nRST,
  valu_issue_sequencer_if.slave io
);
  localparam int BEATS  = VLEN / LANES;
  localparam int BW     = $clog2(BEATS);
  localparam int STAGES = VALU_LAT;
  localparam logic [5:0] VALU_ADD = 6'h00;
  localparam logic [5:0] VALU_SUB = 6'h01;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  typedef struct packed {
    logic [VIDX_W-1:0] vd;
    logic [BW-1:0]     beat;
    logic              mask;
  } pipe_ent_t;

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [VIDX_W-1:0] vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
  logic              mask_q, mask_d;
  logic [5:0]        op_q, op_d, valu_op_q, valu_op_d;
  logic              ill_q, ill_d;
  logic [STAGES:0]   vld_pipe_q, vld_pipe_d;
  pipe_ent_t [STAGES:0] ent_q, ent_d;

  logic rd_en, accept, legal, hazard, ready;

  assign rd_en  = (state_q == ISSUE);
  assign legal  = (io.instr_op == VALU_ADD) || (io.instr_op == VALU_SUB);
  assign ready  = (state_q == IDLE) || ((state_q == DRAIN) && !hazard);
  assign accept = io.instr_valid && ready;

  // A new instruction may not read any register still waiting for writeback.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i <= STAGES; i++)
      if (vld_pipe_q[i] && (ent_q[i].vd == io.instr_vs1 || ent_q[i].vd == io.instr_vs2))
        hazard = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    vd_d    = vd_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    mask_d  = mask_q;
    op_d    = op_q;
    ill_d   = 1'b0;
    case (state_q)
      ISSUE: begin
        if (beat_q == BW'(BEATS-1)) state_d = DRAIN;
        else                        beat_d  = beat_q + 1'b1;
      end
      // Leave once nothing behind the writeback stage remains, so busy drops
      // the cycle after the final writeback.
      DRAIN: if (vld_pipe_q[STAGES-1:0] == '0) state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      if (legal) begin
        state_d = ISSUE;
        beat_d  = '0;
        vd_d    = io.instr_vd;
        vs1_d   = io.instr_vs1;
        vs2_d   = io.instr_vs2;
        mask_d  = io.instr_mask;
        op_d    = io.instr_op;
      end else begin
        ill_d = 1'b1;
      end
    end
  end

  always_comb begin
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], rd_en};
    ent_d[0]   = '{vd: vd_q, beat: beat_q, mask: mask_q};
    for (int i = 1; i <= STAGES; i++) ent_d[i] = ent_q[i-1];
    valu_op_d  = rd_en ? op_q : '0;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      vd_q       <= '0;
      vs1_q      <= '0;
      vs2_q      <= '0;
      mask_q     <= 1'b0;
      op_q       <= '0;
      valu_op_q  <= '0;
      ill_q      <= 1'b0;
      vld_pipe_q <= '0;
      ent_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      vd_q       <= vd_d;
      vs1_q      <= vs1_d;
      vs2_q      <= vs2_d;
      mask_q     <= mask_d;
      op_q       <= op_d;
      valu_op_q  <= valu_op_d;
      ill_q      <= ill_d;
      vld_pipe_q <= vld_pipe_d;
      ent_q      <= ent_d;
    end
  end

  assign io.instr_ready = ready;
  assign io.rf_rd_en    = rd_en;
  assign io.rf_rd_vs1   = rd_en ? vs1_q  : '0;
  assign io.rf_rd_vs2   = rd_en ? vs2_q  : '0;
  assign io.rf_rd_beat  = rd_en ? beat_q : '0;
  assign io.valu_valid  = vld_pipe_q[0];
  assign io.valu_op     = valu_op_q;
  assign io.wb_en       = vld_pipe_q[STAGES];
  assign io.wb_vd       = vld_pipe_q[STAGES] ? ent_q[STAGES].vd   : '0;
  assign io.wb_beat     = vld_pipe_q[STAGES] ? ent_q[STAGES].beat : '0;
  assign io.wb_mask_en  = vld_pipe_q[STAGES] && ent_q[STAGES].mask;
  assign io.instr_done  = vld_pipe_q[STAGES] && (ent_q[STAGES].beat == BW'(BEATS-1));
  assign io.illegal_op  = ill_q;
  assign io.busy        = (state_q != IDLE) || (|vld_pipe_q);
endmodule

// File: tb/tb_valu_issue_sequencer.sv
// Cycle-scheduled reference: every accepted instruction is expanded into
// per-cycle read / issue / writeback events, then compared every cycle.
module tb_valu_issue_sequencer;
  localparam int VLEN = 32, LANES = 4, LAT = 3, VW = 8;
  localparam int BEATS = VLEN / LANES, BW = $clog2(BEATS);
  localparam int N = 4096, NCYC = 3000;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  valu_issue_sequencer_if #(.VIDX_W(VW), .BW(BW)) io();

  valu_issue_sequencer #(.VLEN(VLEN), .LANES(LANES), .VALU_LAT(LAT), .VIDX_W(VW)) dut (
    .CLK(CLK), .nRST(nRST), .io(io)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_err = 0, cyc = 0;

  // per-cycle expected events
  bit          m_rd[N], m_vv[N], m_wb[N], m_ill[N], m_wmask[N];
  logic [VW-1:0] m_rvd[N], m_rvs1[N], m_rvs2[N], m_wvd[N];
  logic [5:0]  m_vop[N];
  int          m_rbeat[N], m_wbeat[N];
  int          last_rd = -1;

  typedef struct {
    int kind;  // 0: instruction, 1: reset while beat 4 is being read
    logic [5:0] op;
    logic [VW-1:0] vd, vs1, vs2;
    logic mk;
    bit wi;    // hold off until the sequencer is idle
  } item_t;
  item_t dq[$];

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", tag, cyc, act, exp);
    end
  endtask

  function automatic item_t mk_item(int kind, logic [5:0] op, int vd, int vs1, int vs2,
                                    logic mk, bit wi);
    item_t it;
    it.kind = kind; it.op = op; it.vd = VW'(vd); it.vs1 = VW'(vs1); it.vs2 = VW'(vs2);
    it.mk = mk; it.wi = wi;
    return it;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_rd[i] = 0; m_vv[i] = 0; m_wb[i] = 0; m_ill[i] = 0;
    end
    last_rd = -1;
  endtask

  task automatic sched(int a, logic [5:0] op, logic [VW-1:0] vd, logic [VW-1:0] vs1,
                       logic [VW-1:0] vs2, logic mk);
    if (op > 6'h01) begin
      m_ill[a+1] = 1;
      return;
    end
    for (int b = 0; b < BEATS; b++) begin
      m_rd[a+1+b] = 1; m_rvd[a+1+b] = vd; m_rvs1[a+1+b] = vs1; m_rvs2[a+1+b] = vs2;
      m_rbeat[a+1+b] = b;
      m_vv[a+2+b] = 1; m_vop[a+2+b] = op;
      m_wb[a+2+LAT+b] = 1; m_wvd[a+2+LAT+b] = vd; m_wbeat[a+2+LAT+b] = b;
      m_wmask[a+2+LAT+b] = mk;
    end
    last_rd = a + BEATS;
  endtask

  // A beat read at r is in flight from r+1 until its writeback at r+1+LAT.
  function automatic bit exp_ready(int t, logic [VW-1:0] vs1, logic [VW-1:0] vs2);
    if (t <= last_rd) return 1'b0;
    for (int r = t - 1 - LAT; r <= t - 1; r++)
      if (r >= 0 && m_rd[r] && (m_rvd[r] == vs1 || m_rvd[r] == vs2)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_busy(int t);
    if (t <= last_rd) return 1'b1;
    for (int r = t - 1 - LAT; r <= t - 1; r++)
      if (r >= 0 && m_rd[r]) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    logic rst_v, v, mk, er, pop, from_dq;
    logic [5:0] op;
    logic [VW-1:0] vd, vs1, vs2;

    io.instr_valid = 0; io.instr_op = '0; io.instr_vd = '0;
    io.instr_vs1 = '0; io.instr_vs2 = '0; io.instr_mask = 0;
    model_clear();

    dq.push_back(mk_item(0, 6'h00, 3, 1, 2, 1'b1, 1'b1));
    dq.push_back(mk_item(0, 6'h01, 5, 6, 7, 1'b0, 1'b0));
    dq.push_back(mk_item(0, 6'h00, 8, 5, 0, 1'b0, 1'b0));
    dq.push_back(mk_item(0, 6'h2A, 1, 1, 1, 1'b0, 1'b1));
    dq.push_back(mk_item(0, 6'h00, 9, 10, 11, 1'b1, 1'b1));
    dq.push_back(mk_item(1, 6'h00, 0, 0, 0, 1'b0, 1'b0));
    dq.push_back(mk_item(0, 6'h01, 4, 2, 3, 1'b0, 1'b1));

    for (int c = 0; c < NCYC; c++) begin
      @(negedge CLK);
      cyc = c;
      rst_v = 1; v = 0; pop = 0; from_dq = 0;
      op = 6'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(2, 63));
      vd = VW'($urandom_range(0, 7)); vs1 = VW'($urandom_range(0, 7));
      vs2 = VW'($urandom_range(0, 7)); mk = 1'($urandom_range(0, 1));
      if (c < 2) rst_v = 0;
      else if (dq.size() > 0) begin
        if (dq[0].kind == 1) begin
          if (m_rd[c] && m_rbeat[c] == 4) begin rst_v = 0; pop = 1; end
        end else if (!(dq[0].wi && exp_busy(c))) begin
          v = 1; from_dq = 1;
          op = dq[0].op; vd = dq[0].vd; vs1 = dq[0].vs1; vs2 = dq[0].vs2; mk = dq[0].mk;
        end
      end else begin
        v = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 299) == 0) rst_v = 0;
      end
      nRST = rst_v; io.instr_valid = v; io.instr_op = op; io.instr_vd = vd;
      io.instr_vs1 = vs1; io.instr_vs2 = vs2; io.instr_mask = mk;
      #1;
      er = exp_ready(c, vs1, vs2);
      chk("instr_ready", io.instr_ready, er);
      chk("rf_rd_en", io.rf_rd_en, m_rd[c]);
      if (m_rd[c]) begin
        chk("rf_rd_vs1", io.rf_rd_vs1, m_rvs1[c]);
        chk("rf_rd_vs2", io.rf_rd_vs2, m_rvs2[c]);
        chk("rf_rd_beat", io.rf_rd_beat, m_rbeat[c]);
      end
      chk("valu_valid", io.valu_valid, m_vv[c]);
      if (m_vv[c]) chk("valu_op", io.valu_op, m_vop[c]);
      chk("wb_en", io.wb_en, m_wb[c]);
      if (m_wb[c]) begin
        chk("wb_vd", io.wb_vd, m_wvd[c]);
        chk("wb_beat", io.wb_beat, m_wbeat[c]);
        chk("wb_mask_en", io.wb_mask_en, m_wmask[c]);
      end
      chk("instr_done", io.instr_done, m_wb[c] && m_wbeat[c] == BEATS - 1);
      chk("illegal_op", io.illegal_op, m_ill[c]);
      chk("busy", io.busy, exp_busy(c));
      @(posedge CLK);
      if (!rst_v) model_clear();
      else if (v && er) begin
        sched(c, op, vd, vs1, vs2, mk);
        if (from_dq) pop = 1;
      end
      if (pop) void'(dq.pop_front());
    end
    chk("dq_drained", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
